// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctrl_mc_fwd_unit.sv
// EX operand forwarding comparator: picks MEM over WB over the register file.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] src_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic            exmem_regwrite_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic            memwb_regwrite_i,
  output fwd_sel_t        sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: load-use stall, EX forwarding, branch flush and multi-cycle EX hold
// with a saturating stall-cycle counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned LAT_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RA_W-1:0]  ifid_rs1_i,
  input  logic [RA_W-1:0]  ifid_rs2_i,
  input  logic             ifid_use1_i,
  input  logic             ifid_use2_i,
  input  logic [RA_W-1:0]  idex_rs1_i,
  input  logic [RA_W-1:0]  idex_rs2_i,
  input  logic [RA_W-1:0]  idex_rd_i,
  input  logic             idex_memread_i,
  input  logic             idex_mc_i,
  input  logic [LAT_W-1:0] idex_mc_lat_i,
  input  logic [RA_W-1:0]  exmem_rd_i,
  input  logic             exmem_regwrite_i,
  input  logic [RA_W-1:0]  memwb_rd_i,
  input  logic             memwb_regwrite_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_noop_o,
  output logic             ex_hold_o,
  output logic             exmem_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hold, load_use, lu_match, stall;
  fwd_sel_t         fwd_a, fwd_b;

  fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .src_i(idex_rs1_i), .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i), .sel_o(fwd_a)
  );

  fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .src_i(idex_rs2_i), .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i), .sel_o(fwd_b)
  );

  assign lu_match = idex_memread_i && (idex_rd_i != '0) &&
                    ((ifid_use1_i && (ifid_rs1_i == idex_rd_i)) ||
                     (ifid_use2_i && (ifid_rs2_i == idex_rd_i)));

  // MC_WAIT with cnt==0 is the release cycle: no hold and no fresh detection of the retained op.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold     = 1'b0;
    load_use = 1'b0;
    case (state_q)
      RUN: begin
        if (idex_mc_i && (idex_mc_lat_i >= LAT_W'(2))) begin
          hold    = 1'b1;
          state_d = MC_WAIT;
          cnt_d   = idex_mc_lat_i - LAT_W'(2);
        end else begin
          load_use = lu_match;
        end
      end
      MC_WAIT: begin
        if (cnt_q != '0) begin
          hold  = 1'b1;
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  assign stall       = hold | load_use;
  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Busy covers the held MC_WAIT cycles; the release cycle already lets the op advance.
  assign busy_o         = ~rst_i & (state_q == MC_WAIT) & (cnt_q != '0);
  assign pc_write_o     = ~rst_i & ~stall;
  assign ifid_stall_o   = ~rst_i & stall;
  assign ifid_flush_o   = ~rst_i & branch_taken_i & ~stall;
  assign idex_noop_o    = ~rst_i & load_use;
  assign ex_hold_o      = ~rst_i & hold;
  assign exmem_bubble_o = ~rst_i & hold;
  assign fwd_a_o        = rst_i ? FWD_REG : fwd_a;
  assign fwd_b_o        = rst_i ? FWD_REG : fwd_b;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: directed scenarios plus randomized traffic
// compared every cycle against a schedule-based reference model.
module tb_hazard_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       ifid_use1, ifid_use2, idex_memread, idex_mc, exmem_wr, memwb_wr, branch;
  logic [3:0] idex_lat;

  logic        pc_write, ifid_stall, ifid_flush, idex_noop, ex_hold, exmem_bubble, busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic        pc_write2, ifid_stall2, ifid_flush2, idex_noop2, ex_hold2, exmem_bubble2, busy2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [1:0]  stall_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.RA_W(5), .LAT_W(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .ifid_rs1_i(ifid_rs1), .ifid_rs2_i(ifid_rs2), .ifid_use1_i(ifid_use1), .ifid_use2_i(ifid_use2),
    .idex_rs1_i(idex_rs1), .idex_rs2_i(idex_rs2), .idex_rd_i(idex_rd),
    .idex_memread_i(idex_memread), .idex_mc_i(idex_mc), .idex_mc_lat_i(idex_lat),
    .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_wr),
    .memwb_rd_i(memwb_rd), .memwb_regwrite_i(memwb_wr), .branch_taken_i(branch),
    .pc_write_o(pc_write), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idex_noop_o(idex_noop), .ex_hold_o(ex_hold), .exmem_bubble_o(exmem_bubble),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .busy_o(busy), .stall_cnt_o(stall_cnt)
  );

  hazard_ctrl_mc #(.RA_W(5), .LAT_W(4), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .ifid_rs1_i(ifid_rs1), .ifid_rs2_i(ifid_rs2), .ifid_use1_i(ifid_use1), .ifid_use2_i(ifid_use2),
    .idex_rs1_i(idex_rs1), .idex_rs2_i(idex_rs2), .idex_rd_i(idex_rd),
    .idex_memread_i(idex_memread), .idex_mc_i(idex_mc), .idex_mc_lat_i(idex_lat),
    .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_wr),
    .memwb_rd_i(memwb_rd), .memwb_regwrite_i(memwb_wr), .branch_taken_i(branch),
    .pc_write_o(pc_write2), .ifid_stall_o(ifid_stall2), .ifid_flush_o(ifid_flush2),
    .idex_noop_o(idex_noop2), .ex_hold_o(ex_hold2), .exmem_bubble_o(exmem_bubble2),
    .fwd_a_o(fwd_a2), .fwd_b_o(fwd_b2), .busy_o(busy2), .stall_cnt_o(stall_cnt2)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] s);
    if (exmem_wr && exmem_rd != 0 && exmem_rd == s) return 2'b10;
    if (memwb_wr && memwb_rd != 0 && memwb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  // Reference model: a multi-cycle op with latency L schedules L-2 further held (busy) cycles
  // followed by one release cycle in which nothing new is detected.
  int holds_left = 0;
  bit rel_now    = 0;
  int mcnt       = 0;

  always @(negedge clk) begin
    logic e_hold, e_lu, e_busy, e_start, e_stall;
    int   cap2;
    e_hold = 0; e_lu = 0; e_busy = 0; e_start = 0;
    if (rst) begin
      holds_left = 0; rel_now = 0; mcnt = 0;
      check("rst_pc_write", pc_write, 0);
      check("rst_stall", ifid_stall, 0);
      check("rst_flush", ifid_flush, 0);
      check("rst_noop", idex_noop, 0);
      check("rst_hold", ex_hold, 0);
      check("rst_busy", busy, 0);
      check("rst_fwd", {fwd_a, fwd_b}, 0);
      check("rst_cnt", stall_cnt, 0);
      check("rst_cnt2", stall_cnt2, 0);
    end else begin
      if (holds_left > 0) begin
        e_hold = 1; e_busy = 1;
      end else if (!rel_now) begin
        if (idex_mc && idex_lat >= 2) begin
          e_hold = 1; e_start = 1;
        end else begin
          e_lu = idex_memread && idex_rd != 0 &&
                 ((ifid_use1 && ifid_rs1 == idex_rd) || (ifid_use2 && ifid_rs2 == idex_rd));
        end
      end
      e_stall = e_hold | e_lu;
      cap2 = (mcnt > 3) ? 3 : mcnt;
      check("pc_write", pc_write, !e_stall);
      check("ifid_stall", ifid_stall, e_stall);
      check("ifid_flush", ifid_flush, branch && !e_stall);
      check("idex_noop", idex_noop, e_lu);
      check("ex_hold", ex_hold, e_hold);
      check("exmem_bubble", exmem_bubble, e_hold);
      check("busy", busy, e_busy);
      check("fwd_a", fwd_a, fwd_ref(idex_rs1));
      check("fwd_b", fwd_b, fwd_ref(idex_rs2));
      check("stall_cnt", stall_cnt, (mcnt > 65535) ? 65535 : mcnt);
      check("stall_cnt2", stall_cnt2, cap2);
      check("dut2_pc_write", pc_write2, !e_stall);
      if (holds_left > 0) begin
        holds_left--;
        rel_now = (holds_left == 0);
      end else if (rel_now) begin
        rel_now = 0;
      end else if (e_start) begin
        holds_left = int'(idex_lat) - 2;
        rel_now    = (idex_lat == 2);
      end
      if (e_stall) mcnt++;
    end
  end

  task automatic idle();
    ifid_rs1 = 0; ifid_rs2 = 0; ifid_use1 = 0; ifid_use2 = 0;
    idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_memread = 0; idex_mc = 0; idex_lat = 0;
    exmem_rd = 0; exmem_wr = 0; memwb_rd = 0; memwb_wr = 0; branch = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h_cnt, b_cnt, c0;
    idle();
    #1;
    check("d_rst_pc_write", pc_write, 0);
    step(); step();
    rst = 0;

    // 1. forwarding priority and register 0
    exmem_rd = 5; exmem_wr = 1; memwb_rd = 5; memwb_wr = 1; idex_rs1 = 5; idex_rs2 = 5;
    #1 check("d_fwd_a_mem", fwd_a, 2'b10);
    exmem_wr = 0;
    #1 check("d_fwd_b_wb", fwd_b, 2'b01);
    exmem_wr = 1; exmem_rd = 0; memwb_rd = 0; idex_rs1 = 0;
    #1 check("d_fwd_a_r0", fwd_a, 2'b00);
    step(); idle();

    // 2. load-use
    idex_memread = 1; idex_rd = 7; ifid_rs2 = 7; ifid_use2 = 1;
    #1 check("d_lu_pc", pc_write, 0);
    check("d_lu_stall", ifid_stall, 1);
    check("d_lu_noop", idex_noop, 1);
    step(); idle();
    #1 check("d_lu_after", pc_write, 1);
    idex_memread = 1; idex_rd = 7; ifid_rs2 = 7; ifid_use2 = 0;
    #1 check("d_lu_nouse", pc_write, 1);
    step(); idle();

    // 3. multi-cycle lat=4, then lat=1
    c0 = stall_cnt; h_cnt = 0; b_cnt = 0;
    idex_mc = 1; idex_lat = 4;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) idex_mc = 0;
      #1;
      h_cnt += (ex_hold && exmem_bubble) ? 1 : 0;
      b_cnt += busy ? 1 : 0;
      step();
    end
    check("d_mc_hold_cycles", h_cnt, 3);
    check("d_mc_busy_cycles", b_cnt, 2);
    check("d_mc_cnt_delta", stall_cnt - 16'(c0), 3);
    idex_mc = 1; idex_lat = 1;
    #1 check("d_lat1_hold", ex_hold, 0);
    check("d_lat1_pc", pc_write, 1);
    step(); idle();

    // 4. hold masks load-use; branch during hold not flushed, flushed on release
    idex_mc = 1; idex_lat = 3; idex_memread = 1; idex_rd = 7; ifid_rs1 = 7; ifid_use1 = 1;
    branch = 1;
    #1 check("d_mask_noop", idex_noop, 0);
    check("d_mask_flush", ifid_flush, 0);
    step();
    #1 check("d_mask_noop2", idex_noop, 0);
    check("d_mask_hold2", ex_hold, 1);
    step();
    #1 check("d_release_flush", ifid_flush, 1);
    step(); idle();

    // 5. async reset in MC_WAIT
    idex_mc = 1; idex_lat = 8;
    step(); step();
    #2 rst = 1;
    #1 check("d_ar_hold", ex_hold, 0);
    check("d_ar_busy", busy, 0);
    check("d_ar_pc", pc_write, 0);
    idex_mc = 0;
    step();
    rst = 0;
    #1 check("d_ar_pc_after", pc_write, 1);
    check("d_ar_busy_after", busy, 0);
    check("d_ar_cnt", stall_cnt, 0);
    step();

    // 6. five stall cycles saturate the 2-bit counter
    idex_memread = 1; idex_rd = 7; ifid_rs1 = 7; ifid_use1 = 1;
    for (int i = 0; i < 5; i++) step();
    idle();
    step();
    check("d_sat_cnt16", stall_cnt, 5);
    check("d_sat_cnt2", stall_cnt2, 3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 149) == 0);
      ifid_rs1     = 5'($urandom_range(0, 3));
      ifid_rs2     = 5'($urandom_range(0, 3));
      ifid_use1    = 1'($urandom_range(0, 1));
      ifid_use2    = 1'($urandom_range(0, 1));
      idex_rs1     = 5'($urandom_range(0, 3));
      idex_rs2     = 5'($urandom_range(0, 3));
      idex_rd      = 5'($urandom_range(0, 3));
      idex_memread = ($urandom_range(0, 2) == 0);
      idex_mc      = ($urandom_range(0, 5) == 0);
      idex_lat     = 4'($urandom_range(0, 15));
      exmem_rd     = 5'($urandom_range(0, 3));
      exmem_wr     = 1'($urandom_range(0, 1));
      memwb_rd     = 5'($urandom_range(0, 3));
      memwb_wr     = 1'($urandom_range(0, 1));
      branch       = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 0;
    idle();
    step(); step();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
